// File: rtl/mig_app_traffic_gen_if.sv
// MIG 7-series user (app) interface: command, write-data and read-data channels.
// The traffic generator uses the master side; the memory controller (or a model of it) uses the slave side.
interface mig_app_traffic_gen_if #(
    parameter int ADDR_WIDTH = 29,
    parameter int DATA_WIDTH = 256
);
    logic [ADDR_WIDTH-1:0]   app_addr;
    logic [2:0]              app_cmd;
    logic                    app_en;
    logic                    app_rdy;
    logic [DATA_WIDTH-1:0]   app_wdf_data;
    logic                    app_wdf_wren;
    logic                    app_wdf_end;
    logic [DATA_WIDTH/8-1:0] app_wdf_mask;
    logic                    app_wdf_rdy;
    logic [DATA_WIDTH-1:0]   app_rd_data;
    logic                    app_rd_data_valid;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );
endinterface

// File: rtl/mig_app_traffic_gen.sv
// Write/read-back DDR3 traffic generator and checker on the MIG app interface (ui_clk domain).
// Optional feature macro: TG_ERR_CAPTURE_EN keeps the first-error index/data capture registers.
module mig_app_traffic_gen #(
    parameter int ADDR_WIDTH    = 29,
    parameter int DATA_WIDTH    = 256,
    parameter int CNT_WIDTH     = 16,
    parameter int ADDR_STEP     = 8,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic                    ui_clk,
    input  logic                    ui_clk_sync_rst,
    input  logic                    init_calib_complete,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [CNT_WIDTH-1:0]    num_words,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [31:0]             seed,
    mig_app_traffic_gen_if.master   app,
    output logic                    busy,
    output logic                    done,
    output logic                    tg_compare_error,
    output logic [CNT_WIDTH-1:0]    err_count,
    output logic [CNT_WIDTH-1:0]    first_err_index,
    output logic [DATA_WIDTH-1:0]   first_err_data
);
    localparam int                    LANES     = DATA_WIDTH / 32;
    localparam int                    TO_WIDTH  = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [31:0]           LANE_STEP = 32'(LANES);
    localparam logic [ADDR_WIDTH-1:0] ADDR_INC  = ADDR_WIDTH'(ADDR_STEP);
    localparam logic [TO_WIDTH-1:0]   TO_LAST   = TO_WIDTH'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT_CAL, ST_WRITE, ST_READ, ST_DRAIN
    } state_t;

    state_t                 state_reg, state_next;
    logic [CNT_WIDTH-1:0]   num_words_reg;
    logic [ADDR_WIDTH-1:0]  base_addr_reg;
    logic [31:0]            seed_reg;
    logic [1:0]             mode_reg;
    logic [CNT_WIDTH-1:0]   cmd_cnt_reg, wd_cnt_reg, rd_cnt_reg;
    logic [CNT_WIDTH-1:0]   cmd_cnt_inc, wd_cnt_inc;
    logic [31:0]            wd_base_reg, rd_base_reg, wd_pat_base;
    logic [TO_WIDTH-1:0]    to_cnt_reg;
    logic                   app_en_reg, app_en_next;
    logic                   app_wdf_wren_reg, app_wdf_wren_next;
    logic [2:0]             app_cmd_reg;
    logic [ADDR_WIDTH-1:0]  app_addr_reg;
    logic [DATA_WIDTH-1:0]  app_wdf_data_reg;
    logic                   busy_reg, busy_next;
    logic                   done_reg, done_next;
    logic                   err_flag_reg;
    logic [CNT_WIDTH-1:0]   err_count_reg;
    logic                   cmd_acc, wd_acc, rd_check, rd_mismatch, timeout_hit;
    logic                   entering_write, entering_read;
    logic [DATA_WIDTH-1:0]  wd_pat, rd_expect;

    assign cmd_acc     = app_en_reg && app.app_rdy;
    assign wd_acc      = app_wdf_wren_reg && app.app_wdf_rdy;
    assign cmd_cnt_inc = cmd_cnt_reg + CNT_WIDTH'(cmd_acc);
    assign wd_cnt_inc  = wd_cnt_reg + CNT_WIDTH'(wd_acc);
    assign rd_check    = (state_reg == ST_READ || state_reg == ST_DRAIN) &&
                         app.app_rd_data_valid && (rd_cnt_reg < num_words_reg);
    assign rd_mismatch = rd_check && (app.app_rd_data != rd_expect);
    assign timeout_hit = (state_reg == ST_DRAIN) && !app.app_rd_data_valid && (to_cnt_reg == TO_LAST);

    assign entering_write = (state_reg == ST_WAIT_CAL) && (state_next == ST_WRITE);
    assign entering_read  = (state_reg != ST_READ) && (state_next == ST_READ);
    assign wd_pat_base    = entering_write ? seed_reg : wd_base_reg + LANE_STEP;

    // Lane k of word i carries seed + i*LANES + k; the *_base registers track seed + i*LANES.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign wd_pat[gi*32 +: 32]    = wd_pat_base + 32'(gi);
            assign rd_expect[gi*32 +: 32] = rd_base_reg + 32'(gi);
        end
    endgenerate

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) state_reg <= ST_IDLE;
        else                 state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (start) state_next = ST_WAIT_CAL;
            ST_WAIT_CAL: if (init_calib_complete) begin
                             if (num_words_reg == '0)     state_next = ST_IDLE;
                             else if (mode_reg == 2'b10)  state_next = ST_READ;
                             else                         state_next = ST_WRITE;
                         end
            ST_WRITE:    if (cmd_cnt_reg == num_words_reg && wd_cnt_reg == num_words_reg)
                             state_next = (mode_reg == 2'b01) ? ST_IDLE : ST_READ;
            ST_READ:     if (cmd_cnt_reg == num_words_reg) state_next = ST_DRAIN;
            ST_DRAIN:    if (rd_cnt_reg == num_words_reg || timeout_hit) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Command and data valids drop only once their own counter has reached num_words.
    always_comb begin
        app_en_next       = 1'b0;
        app_wdf_wren_next = 1'b0;
        if ((state_reg == ST_WRITE || state_reg == ST_READ) && state_next == state_reg)
            app_en_next = (cmd_cnt_inc < num_words_reg);
        if (state_reg == ST_WRITE && state_next == ST_WRITE)
            app_wdf_wren_next = (wd_cnt_inc < num_words_reg);
        busy_next = (state_next != ST_IDLE);
        done_next = (state_reg != ST_IDLE) && (state_next == ST_IDLE);
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            num_words_reg    <= '0;
            base_addr_reg    <= '0;
            seed_reg         <= '0;
            mode_reg         <= '0;
            cmd_cnt_reg      <= '0;
            wd_cnt_reg       <= '0;
            rd_cnt_reg       <= '0;
            wd_base_reg      <= '0;
            rd_base_reg      <= '0;
            to_cnt_reg       <= '0;
            app_en_reg       <= 1'b0;
            app_wdf_wren_reg <= 1'b0;
            app_cmd_reg      <= 3'b000;
            app_addr_reg     <= '0;
            app_wdf_data_reg <= '0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            err_flag_reg     <= 1'b0;
            err_count_reg    <= '0;
        end else begin
            app_en_reg       <= app_en_next;
            app_wdf_wren_reg <= app_wdf_wren_next;
            busy_reg         <= busy_next;
            done_reg         <= done_next;

            if (state_reg == ST_IDLE && start) begin
                num_words_reg <= num_words;
                base_addr_reg <= base_addr;
                seed_reg      <= seed;
                mode_reg      <= mode;
                err_flag_reg  <= 1'b0;
                err_count_reg <= '0;
            end

            if (entering_write || entering_read) begin
                cmd_cnt_reg  <= '0;
                app_addr_reg <= base_addr_reg;
                app_cmd_reg  <= entering_read ? 3'b001 : 3'b000;
            end else if (cmd_acc) begin
                cmd_cnt_reg  <= cmd_cnt_inc;
                app_addr_reg <= app_addr_reg + ADDR_INC;
            end

            if (entering_write || wd_acc) begin
                wd_cnt_reg       <= entering_write ? '0 : wd_cnt_inc;
                wd_base_reg      <= wd_pat_base;
                app_wdf_data_reg <= wd_pat;
            end

            if (entering_read) begin
                rd_cnt_reg  <= '0;
                rd_base_reg <= seed_reg;
            end else if (rd_check) begin
                rd_cnt_reg  <= rd_cnt_reg + CNT_ONE;
                rd_base_reg <= rd_base_reg + LANE_STEP;
            end

            if (rd_mismatch) begin
                if (err_count_reg != '1) err_count_reg <= err_count_reg + CNT_ONE;
                err_flag_reg <= 1'b1;
            end
            if (timeout_hit) err_flag_reg <= 1'b1;

            // Counts consecutive return-free cycles; any return or leaving DRAIN restarts it.
            to_cnt_reg <= (state_reg == ST_DRAIN && !app.app_rd_data_valid) ?
                          to_cnt_reg + TO_WIDTH'(1) : '0;
        end
    end

`ifdef TG_ERR_CAPTURE_EN
    logic [CNT_WIDTH-1:0]  first_err_index_reg;
    logic [DATA_WIDTH-1:0] first_err_data_reg;

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            first_err_index_reg <= '0;
            first_err_data_reg  <= '0;
        end else if (state_reg == ST_IDLE && start) begin
            first_err_index_reg <= '0;
            first_err_data_reg  <= '0;
        end else if (rd_mismatch && err_count_reg == '0) begin
            first_err_index_reg <= rd_cnt_reg;
            first_err_data_reg  <= app.app_rd_data;
        end
    end

    assign first_err_index = first_err_index_reg;
    assign first_err_data  = first_err_data_reg;
`else
    assign first_err_index = '0;
    assign first_err_data  = '0;
`endif

    assign app.app_en       = app_en_reg;
    assign app.app_cmd      = app_cmd_reg;
    assign app.app_addr     = app_addr_reg;
    assign app.app_wdf_wren = app_wdf_wren_reg;
    assign app.app_wdf_end  = app_wdf_wren_reg;
    assign app.app_wdf_data = app_wdf_data_reg;
    assign app.app_wdf_mask = '0;
    assign busy             = busy_reg;
    assign done             = done_reg;
    assign tg_compare_error = err_flag_reg;
    assign err_count        = err_count_reg;
endmodule

// File: tb/tb_mig_app_traffic_gen.sv
// Bench for mig_app_traffic_gen: a MIG app-interface memory model with a scoreboard of
// expected commands and write data, plus end-of-run checks of the done/error outputs.
module tb_mig_app_traffic_gen;
    localparam int AW = 29;
    localparam int DW = 256;
    localparam int CW = 16;

    logic           ui_clk = 1'b0;
    logic           ui_clk_sync_rst;
    logic           init_calib_complete;
    logic           start;
    logic [1:0]     mode;
    logic [CW-1:0]  num_words;
    logic [AW-1:0]  base_addr;
    logic [31:0]    seed;
    logic           busy, done, tg_compare_error;
    logic [CW-1:0]  err_count, first_err_index;
    logic [DW-1:0]  first_err_data;

    mig_app_traffic_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) app_bus ();

    mig_app_traffic_gen #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .ADDR_STEP(8), .DRAIN_TIMEOUT(4096)
    ) dut (
        .ui_clk              (ui_clk),
        .ui_clk_sync_rst     (ui_clk_sync_rst),
        .init_calib_complete (init_calib_complete),
        .start               (start),
        .mode                (mode),
        .num_words           (num_words),
        .base_addr           (base_addr),
        .seed                (seed),
        .app                 (app_bus),
        .busy                (busy),
        .done                (done),
        .tg_compare_error    (tg_compare_error),
        .err_count           (err_count),
        .first_err_index     (first_err_index),
        .first_err_data      (first_err_data)
    );

    always #5 ui_clk = ~ui_clk;

    int vec_count = 0;
    int miscompare_count = 0;

    task automatic check_value(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompare_count++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pattern(input logic [31:0] s, input int idx);
        logic [DW-1:0] w;
        for (int k = 0; k < DW/32; k++) w[k*32 +: 32] = s + 32'(idx * (DW/32)) + 32'(k);
        return w;
    endfunction

    // Scoreboard queues filled by the stimulus, drained by the model on every accepted beat.
    logic [AW+2:0] exp_cmd_q[$];
    logic [DW-1:0] exp_wdata_q[$];
    // Memory model state
    logic [AW-1:0] wcmd_q[$];
    logic [AW-1:0] rcmd_q[$];
    logic [DW-1:0] wdata_q[$];
    logic [DW-1:0] mem [logic [AW-1:0]];

    bit rdy_random = 1'b0;
    bit drop_last = 1'b0;
    bit hold_check_en = 1'b1;
    int corrupt_idx = -1;
    int run_num = 0;
    int rd_ret_idx = 0;
    int wr_cmd_n = 0, wr_dat_n = 0, rd_cmd_n = 0;
    int done_count = 0, en_seen = 0;

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          cmd_stall, wd_stall;
        logic [AW+3:0] prev_cmd;
        logic [DW-1:0] prev_wdata;
        cmd_stall = 1'b0;
        wd_stall  = 1'b0;
        prev_cmd  = '0;
        prev_wdata = '0;
        app_bus.app_rdy = 1'b0;
        app_bus.app_wdf_rdy = 1'b0;
        app_bus.app_rd_data_valid = 1'b0;
        app_bus.app_rd_data = '0;
        forever begin
            @(negedge ui_clk);
            if (done) done_count++;
            if (app_bus.app_en) en_seen++;
            if (cmd_stall)
                check_value("cmd_hold", {app_bus.app_en, app_bus.app_cmd, app_bus.app_addr}, prev_cmd);
            if (wd_stall) begin
                check_value("wren_hold", app_bus.app_wdf_wren, 1);
                check_value("wdata_hold", app_bus.app_wdf_data, prev_wdata);
            end

            // Read returns come from reads accepted on earlier edges only.
            app_bus.app_rd_data_valid = 1'b0;
            if (rcmd_q.size() > 0 && (!rdy_random || $urandom_range(0, 1) == 1)) begin
                a = rcmd_q.pop_front();
                d = mem.exists(a) ? mem[a] : '0;
                if (rd_ret_idx == corrupt_idx) d[0] = ~d[0];
                if (!(drop_last && rd_ret_idx == run_num - 1)) begin
                    app_bus.app_rd_data_valid = 1'b1;
                    app_bus.app_rd_data = d;
                end
                rd_ret_idx++;
            end

            app_bus.app_rdy = rdy_random ? ($urandom_range(0, 2) != 0) : 1'b1;
            app_bus.app_wdf_rdy = (rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1) && (wdata_q.size() < 4);

            if (app_bus.app_en && app_bus.app_rdy) begin
                check_value("cmd_expected", exp_cmd_q.size() > 0, 1);
                if (exp_cmd_q.size() > 0)
                    check_value("cmd_addr", {app_bus.app_cmd, app_bus.app_addr}, exp_cmd_q.pop_front());
                if (app_bus.app_cmd == 3'b000) begin
                    wcmd_q.push_back(app_bus.app_addr);
                    wr_cmd_n++;
                end else begin
                    rcmd_q.push_back(app_bus.app_addr);
                    rd_cmd_n++;
                end
            end
            if (app_bus.app_wdf_wren && app_bus.app_wdf_rdy) begin
                check_value("wdata_expected", exp_wdata_q.size() > 0, 1);
                if (exp_wdata_q.size() > 0)
                    check_value("wdata", app_bus.app_wdf_data, exp_wdata_q.pop_front());
                check_value("wdf_end_mask", {app_bus.app_wdf_end, app_bus.app_wdf_mask}, {1'b1, 32'h0});
                wdata_q.push_back(app_bus.app_wdf_data);
                wr_dat_n++;
            end
            while (wcmd_q.size() > 0 && wdata_q.size() > 0) mem[wcmd_q.pop_front()] = wdata_q.pop_front();

            cmd_stall  = hold_check_en && app_bus.app_en && !app_bus.app_rdy;
            prev_cmd   = {app_bus.app_en, app_bus.app_cmd, app_bus.app_addr};
            wd_stall   = hold_check_en && app_bus.app_wdf_wren && !app_bus.app_wdf_rdy;
            prev_wdata = app_bus.app_wdf_data;
        end
    end

    task automatic push_expected(input logic [1:0] m, input int n, input logic [AW-1:0] b, input logic [31:0] s);
        if (m != 2'b10)
            for (int i = 0; i < n; i++) begin
                exp_cmd_q.push_back({3'b000, b + AW'(i * 8)});
                exp_wdata_q.push_back(pattern(s, i));
            end
        if (m != 2'b01)
            for (int i = 0; i < n; i++) exp_cmd_q.push_back({3'b001, b + AW'(i * 8)});
    endtask

    task automatic run_test(input string name, input logic [1:0] m, input int n, input logic [AW-1:0] b,
                            input logic [31:0] s, input bit rnd, input int corrupt, input bit drop,
                            input int exp_err, input bit exp_flag);
        int dc0;
        bit got_done;
        logic [CW-1:0] exp_fi;
        logic [DW-1:0] exp_fd;
        exp_fi = '0;
        exp_fd = '0;
        rdy_random = rnd;
        corrupt_idx = corrupt;
        drop_last = drop;
        run_num = n;
        rd_ret_idx = 0;
        wr_cmd_n = 0;
        wr_dat_n = 0;
        rd_cmd_n = 0;
        push_expected(m, n, b, s);
        @(negedge ui_clk);
        mode = m;
        num_words = CW'(n);
        base_addr = b;
        seed = s;
        start = 1'b1;
        dc0 = done_count;
        @(negedge ui_clk);
        start = 1'b0;
        got_done = 1'b0;
        for (int c = 0; c < 8000 && !got_done; c++) begin
            if (done) got_done = 1'b1;
            else @(negedge ui_clk);
        end
        check_value({name, "_done_seen"}, got_done, 1);
        repeat (3) @(negedge ui_clk);
        check_value({name, "_done_pulses"}, done_count - dc0, 1);
        check_value({name, "_busy"}, busy, 0);
        check_value({name, "_err_count"}, err_count, exp_err);
        check_value({name, "_flag"}, tg_compare_error, exp_flag);
        check_value({name, "_wr_cmds"}, wr_cmd_n, (m != 2'b10) ? n : 0);
        check_value({name, "_wr_beats"}, wr_dat_n, (m != 2'b10) ? n : 0);
        check_value({name, "_rd_cmds"}, rd_cmd_n, (m != 2'b01) ? n : 0);
        check_value({name, "_sb_left"}, exp_cmd_q.size() + exp_wdata_q.size(), 0);
`ifdef TG_ERR_CAPTURE_EN
        if (corrupt >= 0) begin
            exp_fi = CW'(corrupt);
            exp_fd = pattern(s, corrupt);
            exp_fd[0] = ~exp_fd[0];
        end
`endif
        check_value({name, "_first_idx"}, first_err_index, exp_fi);
        check_value({name, "_first_data"}, first_err_data, exp_fd);
        $display("run %s: mode=%0d words=%0d err_count=%0d flag=%0d", name, m, n, err_count, tg_compare_error);
        exp_cmd_q.delete();
        exp_wdata_q.delete();
        rdy_random = 1'b0;
        drop_last = 1'b0;
        corrupt_idx = -1;
    endtask

    initial begin
        int dc0;
        bit hit;
        ui_clk_sync_rst = 1'b1;
        init_calib_complete = 1'b0;
        start = 1'b0;
        mode = 2'b00;
        num_words = '0;
        base_addr = '0;
        seed = '0;
        repeat (3) @(negedge ui_clk);
        ui_clk_sync_rst = 1'b0;
        @(negedge ui_clk);
        check_value("rst_app_en", app_bus.app_en, 0);
        check_value("rst_wren", app_bus.app_wdf_wren, 0);
        check_value("rst_cmd_addr", {app_bus.app_cmd, app_bus.app_addr}, 0);
        check_value("rst_wdata", app_bus.app_wdf_data, 0);
        check_value("rst_status", {busy, done, tg_compare_error}, 0);
        check_value("rst_err_count", err_count, 0);
        check_value("rst_first", {first_err_index, first_err_data[31:0]}, 0);
        $display("run reset: outputs checked after reset release");

        // num_words = 0: done exactly one cycle after calibration, no commands
        mode = 2'b00;
        num_words = '0;
        start = 1'b1;
        @(negedge ui_clk);
        start = 1'b0;
        repeat (3) @(negedge ui_clk);
        check_value("zero_wait_busy", busy, 1);
        check_value("zero_wait_done", done, 0);
        init_calib_complete = 1'b1;
        @(negedge ui_clk);
        check_value("zero_done", done, 1);
        repeat (2) @(negedge ui_clk);
        check_value("zero_busy", busy, 0);
        check_value("zero_no_en", en_seen, 0);
        $display("run zero_words: done_count=%0d", done_count);

        run_test("basic",    2'b00, 10, 29'h0,          32'h0,         1'b0, -1, 1'b0, 0, 1'b0);
        run_test("random",   2'b00, 10, 29'h100,        32'h1234_5678, 1'b1, -1, 1'b0, 0, 1'b0);
        run_test("corrupt",  2'b00, 10, 29'h1000,       32'hdead_beef, 1'b0,  3, 1'b0, 1, 1'b1);
        run_test("wrap",     2'b00,  4, 29'h1fff_fff0,  32'h7,         1'b0, -1, 1'b0, 0, 1'b0);
        run_test("wr_only",  2'b01,  5, 29'h2000,       32'd99,        1'b1, -1, 1'b0, 0, 1'b0);
        run_test("rd_only",  2'b10,  5, 29'h2000,       32'd99,        1'b1, -1, 1'b0, 0, 1'b0);
        run_test("mode11",   2'b11,  3, 29'h3000,       32'hffff_fffe, 1'b0, -1, 1'b0, 0, 1'b0);
        run_test("timeout",  2'b00,  4, 29'h4000,       32'h55,        1'b0, -1, 1'b1, 0, 1'b1);

        // Reset during WRITE, then read back the image written by the "basic" run
        push_expected(2'b00, 10, 29'h0, 32'h0);
        wr_cmd_n = 0;
        @(negedge ui_clk);
        mode = 2'b00;
        num_words = CW'(10);
        base_addr = '0;
        seed = '0;
        start = 1'b1;
        @(negedge ui_clk);
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            if (wr_cmd_n >= 3) hit = 1'b1;
            else @(negedge ui_clk);
        end
        check_value("rst_mid_reached", hit, 1);
        hold_check_en = 1'b0;
        @(negedge ui_clk);
        ui_clk_sync_rst = 1'b1;
        dc0 = done_count;
        @(negedge ui_clk);
        ui_clk_sync_rst = 1'b0;
        check_value("rst_mid_en", {app_bus.app_en, app_bus.app_wdf_wren}, 0);
        check_value("rst_mid_busy", busy, 0);
        check_value("rst_mid_done", done, 0);
        exp_cmd_q.delete();
        exp_wdata_q.delete();
        wcmd_q.delete();
        wdata_q.delete();
        repeat (3) @(negedge ui_clk);
        check_value("rst_mid_no_done", done_count - dc0, 0);
        hold_check_en = 1'b1;
        $display("run reset_mid_write: aborted after %0d write commands", wr_cmd_n);
        run_test("rd_after_rst", 2'b10, 10, 29'h0, 32'h0, 1'b0, -1, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
        $finish;
    end
endmodule

// File: doc/mig_app_traffic_gen.md
# mig_app_traffic_gen

Parametrised write/read-back traffic generator and checker for the MIG 7-series DDR3 user (app) interface, clocked in the MIG `ui_clk` domain. On `start` it streams a programmable number of pattern words to consecutive DDR3 addresses, reads them back, and compares every returned word against the regenerated pattern. It replaces the fixed-count, fixed-pattern bring-up sequencer and adds:

- runtime length, base address and seed;
- write-only and read-only modes;
- independent command and write-data channels;
- a drain timeout, an error counter and a done/busy handshake.

## Interface
Parameters:
- `ADDR_WIDTH`, 29, width of `app_addr`.
- `DATA_WIDTH`, 256, app data width; must be a multiple of 32.
- `CNT_WIDTH`, 16, width of `num_words` and of the internal counters.
- `ADDR_STEP`, 8, address increment per word (one BL8 burst).
- `DRAIN_TIMEOUT`, 4096, `ui_clk` cycles allowed in DRAIN without a read return.

Ports:
- `ui_clk`  in  1  sole clock.
- `ui_clk_sync_rst`  in  1  reset: one clock; reset is synchronous and active-high.
- `init_calib_complete`  in  1  MIG calibration done.
- `start`  in  1  single-cycle start pulse; sampled only in IDLE.
- `mode`  in  2  00 write then read, 01 write only, 10 read only, 11 treated as 00.
- `num_words`  in  CNT_WIDTH  words per run; sampled on `start`.
- `base_addr`  in  ADDR_WIDTH  first address; sampled on `start`.
- `seed`  in  32  pattern seed; sampled on `start`.
- `app_addr`  out  ADDR_WIDTH  command address.
- `app_cmd`  out  3  000 write, 001 read.
- `app_en`  out  1  command valid.
- `app_rdy`  in  1  command accepted when `app_en && app_rdy`.
- `app_wdf_data`  out  DATA_WIDTH  write data.
- `app_wdf_wren`  out  1  write data valid.
- `app_wdf_end`  out  1  equal to `app_wdf_wren`.
- `app_wdf_mask`  out  DATA_WIDTH/8  constant 0.
- `app_wdf_rdy`  in  1  data accepted when `app_wdf_wren && app_wdf_rdy`.
- `app_rd_data`  in  DATA_WIDTH  read data.
- `app_rd_data_valid`  in  1  read data strobe.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse on the transition into IDLE at end of a run.
- `tg_compare_error`  out  1  sticky mismatch/timeout flag; cleared on `start`.
- `err_count`  out  CNT_WIDTH  mismatching words this run; saturates at all-ones.
- `first_err_index`  out  CNT_WIDTH  index of the first mismatching word.
- `first_err_data`  out  DATA_WIDTH  read data of the first mismatching word.

## Operation
- States: IDLE, WAIT_CAL, WRITE, READ, DRAIN.
- IDLE → WAIT_CAL on `start`. Inputs are latched and error state is cleared on that edge.
- WAIT_CAL → WRITE (mode 00/01/11) or READ (mode 10) once `init_calib_complete` is high.
- If `num_words` == 0, WAIT_CAL → IDLE with `done` and no app traffic.
- WRITE: command and data channels run independently.
  - `cmd_cnt` counts accepted commands; `wd_cnt` counts accepted data beats. Each stops at `num_words`.
  - `app_en` stays high with `app_cmd`=000 until `cmd_cnt` reaches `num_words`.
  - `app_wdf_wren` stays high until `wd_cnt` reaches `num_words`.
  - When both counters reach `num_words`: → READ (mode 00/11), or → IDLE with `done` (mode 01).
- READ: `app_en` high with `app_cmd`=001 until `num_words` read commands are accepted, then → DRAIN.
- Read returns are counted in `rd_cnt` and checked in order in READ and DRAIN. `app_rd_data_valid` is ignored in all other states.
- DRAIN → IDLE with `done` when `rd_cnt` == `num_words`.
- DRAIN timeout: if `DRAIN_TIMEOUT` consecutive cycles pass with no read return, set `tg_compare_error` and go → IDLE with `done`.
- Address for word i = `base_addr` + i·`ADDR_STEP`, modulo 2^ADDR_WIDTH (wraps silently).
- Pattern: 32-bit lane k of word i = `seed` + i·(DATA_WIDTH/32) + k, modulo 2^32.
- Mismatch on word r: `err_count` += 1 (saturating) and `tg_compare_error` is set. On the first mismatch, capture r and the returned data.
- `start` while `busy` is ignored.

## Timing
- All outputs are registered.
- Reset values: `app_en`=0, `app_wdf_wren`=0, `app_cmd`=000, `app_addr`=0, `app_wdf_data`=0, `busy`=0, `done`=0, `tg_compare_error`=0, `err_count`=0, `first_err_*`=0.
- Reset asserted mid-run returns to IDLE on the next edge with `app_en`/`app_wdf_wren` low, and `done` is not pulsed.
- `app_en`/`app_addr` and `app_wdf_wren`/`app_wdf_data` hold stable while the matching ready signal is low.
- On an accept edge, the next address or data is presented the following cycle with no bubble. Full rate is one command per cycle while `app_rdy` stays high.
- First write command appears 1 cycle after entering WRITE.
- Compare result (`err_count`, flag) updates 1 cycle after `app_rd_data_valid`.
- `done` is asserted 1 cycle after the final compare.

## Configuration
- `TG_ERR_CAPTURE_EN` defined: the `first_err_index` and `first_err_data` capture registers exist and behave as above.
- `TG_ERR_CAPTURE_EN` undefined: both outputs are tied to 0 and the capture registers are removed. `err_count` and `tg_compare_error` are unaffected.

## Test plan
- Mode 00, `num_words`=10, `base_addr`=0, `seed`=0, ideal MIG model → addresses 0..72 in steps of 8 for both writes and reads; `done` pulses once; `err_count`=0; flag low.
- Random `app_rdy`/`app_wdf_rdy` deasserts, data leading commands by up to 4 beats → exactly 10 commands and 10 data beats; no address or data changes while not ready; zero errors.
- Model corrupts read word 3, bit 0 → `err_count`=1, `tg_compare_error`=1, `first_err_index`=3 (capture only with `TG_ERR_CAPTURE_EN`).
- `base_addr`=2^29−16, `num_words`=4 → addresses wrap to 0 and 8; data intact.
- Model drops the last read return → after 4096 idle cycles the flag sets and `done` pulses; `num_words`=0 → `done` 1 cycle after calibration, no `app_en`.
- Reset asserted mid-WRITE → next cycle IDLE with `app_en`=0 and no `done`; a following `start` in mode 10 checks the previously written data with zero errors.
